// File: rtl/mips_defs.sv
// mips_defs
// Shared MIPS definitions used by the decode stage and its register file:
// opcode/funct constants, the ID/EX control-bundle layout, the NOP word and
// a helper that maps an opcode onto its control bundle.
package mips_defs;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDI  = 6'h08,
        OP_SLTI  = 6'h0A,
        OP_ANDI  = 6'h0C,
        OP_ORI   = 6'h0D,
        OP_LUI   = 6'h0F,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_e;

    localparam logic [5:0] FUNCT_SLL = 6'h00;
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    localparam logic [31:0] NOP_WORD = '0;

    typedef struct packed {
        logic reg_dst;
        logic alu_src;
        logic mem_to_reg;
        logic reg_write;
        logic mem_read;
        logic mem_write;
    } ctrl_t;

    // Branches and jumps resolve in ID, so they carry no EX/MEM/WB control.
    function automatic ctrl_t decode_ctrl(input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OP_RTYPE: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            OP_LW: begin
                c.alu_src    = 1'b1;
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
                c.mem_read   = 1'b1;
            end
            OP_SW: begin
                c.alu_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: begin
                c.alu_src   = 1'b1;
                c.reg_write = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/register_file.sv
// register_file
// 32 x B register file, two asynchronous read ports, one synchronous write
// port. r0 reads as zero and ignores writes. A write presented in the same
// cycle as a read of that register is bypassed to the read port.
// Ports: clk, reset (async, active-low), we/wa/wd (write port),
//        ra1/ra2 (read addresses), rd1/rd2 (read data).
module register_file
    import mips_defs::*;
#(
    parameter int B = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         we,
    input  logic [4:0]   wa,
    input  logic [B-1:0] wd,
    input  logic [4:0]   ra1,
    input  logic [4:0]   ra2,
    output logic [B-1:0] rd1,
    output logic [B-1:0] rd2
);

    logic [B-1:0] regs [32];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != 5'd0)) begin
            regs[wa] <= wd;
        end
    end

    always_comb begin
        rd1 = '0;
        if (ra1 != 5'd0) begin
            rd1 = (we && (wa == ra1)) ? wd : regs[ra1];
        end
    end

    always_comb begin
        rd2 = '0;
        if (ra2 != 5'd0) begin
            rd2 = (we && (wa == ra2)) ? wd : regs[ra2];
        end
    end

endmodule

// File: rtl/instruction_decode.sv
// instruction_decode
// MIPS ID stage: IF/ID register, register file read, control decode,
// branch/jump resolution fed back to fetch, and the ID/EX register.
// Ports: clk, reset (async, active-low); instruction/pc_incrementado from
// fetch; wb_reg_write/wb_write_reg/wb_write_data from write-back;
// pc_branch/pc_jump/PCSrc/jump/stall back to fetch; ex_* = ID/EX register.
// Optional macro ID_LOAD_USE_STALL_EN enables the load-use stall; when it is
// undefined, stall is tied low.
module instruction_decode
    import mips_defs::*;
#(
    parameter int B = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [B-1:0] instruction,
    input  logic [B-1:0] pc_incrementado,
    input  logic         wb_reg_write,
    input  logic [4:0]   wb_write_reg,
    input  logic [B-1:0] wb_write_data,
    output logic [B-1:0] pc_branch,
    output logic [B-1:0] pc_jump,
    output logic         PCSrc,
    output logic         jump,
    output logic         stall,
    output logic [B-1:0] ex_read_data1,
    output logic [B-1:0] ex_read_data2,
    output logic [B-1:0] ex_sign_ext,
    output logic [4:0]   ex_rs,
    output logic [4:0]   ex_rt,
    output logic [4:0]   ex_rd,
    output logic [5:0]   ex_funct,
    output logic [5:0]   ex_opcode,
    output logic         ex_RegDst,
    output logic         ex_ALUSrc,
    output logic         ex_MemtoReg,
    output logic         ex_RegWrite,
    output logic         ex_MemRead,
    output logic         ex_MemWrite
);

    logic [B-1:0] if_instr;
    logic [B-1:0] if_pc;

    logic [5:0]   opcode;
    logic [4:0]   rs, rt, rd;
    logic [5:0]   funct;
    logic [15:0]  imm;
    logic [25:0]  target;
    logic [B-1:0] read_data1, read_data2;
    logic [B-1:0] imm_ext, imm_sext;
    ctrl_t        ctl;
    logic         redirect;

    assign opcode = if_instr[31:26];
    assign rs     = if_instr[25:21];
    assign rt     = if_instr[20:16];
    assign rd     = if_instr[15:11];
    assign funct  = if_instr[5:0];
    assign imm    = if_instr[15:0];
    assign target = if_instr[25:0];

    register_file #(.B(B)) u_regfile (
        .clk   (clk),
        .reset (reset),
        .we    (wb_reg_write),
        .wa    (wb_write_reg),
        .wd    (wb_write_data),
        .ra1   (rs),
        .ra2   (rt),
        .rd1   (read_data1),
        .rd2   (read_data2)
    );

    assign ctl      = decode_ctrl(opcode);
    assign imm_sext = {{(B-16){imm[15]}}, imm};
    assign imm_ext  = ((opcode == OP_ANDI) || (opcode == OP_ORI)) ? {{(B-16){1'b0}}, imm} : imm_sext;

`ifdef ID_LOAD_USE_STALL_EN
    assign stall = ex_MemRead && (ex_rt != 5'd0) && ((ex_rt == rs) || (ex_rt == rt));
`else
    assign stall = 1'b0;
`endif

    // Redirects are suppressed during a stall so the held IF/ID word is
    // re-evaluated once the load result is available.
    assign pc_branch = if_pc + {imm_sext[B-3:0], 2'b00};
    assign pc_jump   = {if_pc[B-1:28], target, 2'b00};
    assign PCSrc     = !stall && (((opcode == OP_BEQ) && (read_data1 == read_data2)) ||
                                  ((opcode == OP_BNE) && (read_data1 != read_data2)));
    assign jump      = !stall && (opcode == OP_J);
    assign redirect  = PCSrc || jump;

    // IF/ID: a redirect flushes the slot behind the branch (no delay slot).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_instr <= NOP_WORD;
            if_pc    <= '0;
        end else if (redirect) begin
            if_instr <= NOP_WORD;
            if_pc    <= '0;
        end else if (!stall) begin
            if_instr <= instruction;
            if_pc    <= pc_incrementado;
        end
    end

    // ID/EX: a stall inserts an all-zero bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset || stall) begin
            ex_read_data1 <= '0;
            ex_read_data2 <= '0;
            ex_sign_ext   <= '0;
            ex_rs         <= '0;
            ex_rt         <= '0;
            ex_rd         <= '0;
            ex_funct      <= '0;
            ex_opcode     <= '0;
            ex_RegDst     <= 1'b0;
            ex_ALUSrc     <= 1'b0;
            ex_MemtoReg   <= 1'b0;
            ex_RegWrite   <= 1'b0;
            ex_MemRead    <= 1'b0;
            ex_MemWrite   <= 1'b0;
        end else begin
            ex_read_data1 <= read_data1;
            ex_read_data2 <= read_data2;
            ex_sign_ext   <= imm_ext;
            ex_rs         <= rs;
            ex_rt         <= rt;
            ex_rd         <= rd;
            ex_funct      <= funct;
            ex_opcode     <= opcode;
            ex_RegDst     <= ctl.reg_dst;
            ex_ALUSrc     <= ctl.alu_src;
            ex_MemtoReg   <= ctl.mem_to_reg;
            ex_RegWrite   <= ctl.reg_write;
            ex_MemRead    <= ctl.mem_read;
            ex_MemWrite   <= ctl.mem_write;
        end
    end

endmodule

// File: doc/instruction_decode.md
# instruction_decode

Second pipeline stage of the MIPS datapath, directly downstream of `instruction_fetch`. Latches the fetched instruction and `pc_incrementado` (IF/ID register), reads the register file, generates control, resolves branches/jumps in ID and drives `pc_branch`/`pc_jump`/`PCSrc`/`jump` back to fetch, then registers operands and control into the ID/EX register.

## Interface
- `B`, 32, datapath/PC width
- `clk` in 1 — rising-edge clock
- `reset` in 1 — one clock; reset is asynchronous and active-low
- `instruction` in B — fetched word (valid before rising edge)
- `pc_incrementado` in B — PC+4 from fetch
- `wb_reg_write` in 1 — write-back enable
- `wb_write_reg` in 5 — write-back destination
- `wb_write_data` in B — write-back data
- `pc_branch` out B — branch target to fetch
- `pc_jump` out B — jump target to fetch
- `PCSrc` out 1 — branch taken
- `jump` out 1 — J taken
- `stall` out 1 — load-use stall request
- `ex_read_data1`, `ex_read_data2` out B — registered rs/rt values
- `ex_sign_ext` out B — registered immediate (sign- or zero-extended)
- `ex_rs`, `ex_rt`, `ex_rd` out 5 — registered register fields
- `ex_funct` out 6, `ex_opcode` out 6 — registered for ALU control
- `ex_RegDst`, `ex_ALUSrc`, `ex_MemtoReg`, `ex_RegWrite`, `ex_MemRead`, `ex_MemWrite` out 1 — registered control

## Operation
- IF/ID register: captures `instruction`, `pc_incrementado` each edge unless `stall`=1 (hold). When `PCSrc`|`jump`=1 it loads 0 (nop) instead: no delay slot.
- Register file: 32×B, two async reads, one sync write on rising edge. r0 always reads 0, writes to r0 ignored. Write-to-read bypass: if `wb_reg_write` and `wb_write_reg`==rs/rt (≠0), the read returns `wb_write_data` in the same cycle.
- Supported opcodes: R-type 0x00, lw 0x23, sw 0x2B, beq 0x04, bne 0x05, j 0x02, addi 0x08, slti 0x0A, andi 0x0C, ori 0x0D, lui 0x0F. Any other opcode: all control 0 (nop).
- Immediate: andi/ori zero-extend, all others sign-extend.
- Branch: `pc_branch` = IF/ID PC + (sext(imm)<<2), 32-bit wrap. `PCSrc` = (beq & rs==rt) | (bne & rs≠rt), compare on bypassed read values only; no EX/MEM forwarding.
- Jump: `pc_jump` = {IF/ID PC[31:28], target[25:0], 2'b00}; `jump` = opcode==0x02.
- `PCSrc` and `jump` are forced 0 while `stall`=1.
- ID/EX register: loads decoded values each edge; loads all-zero control (bubble) when `stall`=1.

## Timing
- Reset (asserted low): IF/ID=0, all `ex_*` outputs=0; hence `PCSrc`=`jump`=`stall`=0 and targets are derived from zero.
- `pc_branch`, `pc_jump`, `PCSrc`, `jump`, `stall` are combinational from IF/ID and ID/EX state. Fetch samples them at the next edge, so the redirect costs 1 flushed slot.
- Decode-to-`ex_*` latency: 1 cycle after the IF/ID capture.
- Reset deassertion mid-stream: the first edge after release captures normally. Reset asserted mid-operation clears state asynchronously.

## Configuration
- `ID_LOAD_USE_STALL_EN` defined: `stall` = `ex_MemRead` & `ex_rt`≠0 & (`ex_rt`==rs | `ex_rt`==rt of IF/ID instruction). Holds IF/ID and bubbles ID/EX for 1 cycle.
- Undefined: `stall` tied 0, no hold/bubble logic.

## Structure
- Shared package `mips_defs`: opcode and funct constants, control-bundle field layout, NOP word (0).
- Sub-module `register_file` (32×B, 2R1W, bypass, r0 hardwired). Decoder, branch unit and pipeline registers stay in `instruction_decode`.

## Test plan
- Reset low with random inputs → all `ex_*`=0, `PCSrc`=`jump`=0; release → next edge captures the presented instruction.
- WB writes r5=0x1234 while `addi r6,r5,1` decodes → `ex_read_data1`=0x1234, `ex_sign_ext`=1, `ex_ALUSrc`=`ex_RegWrite`=1.
- r1=r2=7, `beq r1,r2,-2` at PC+4=0x100 → `PCSrc`=1, `pc_branch`=0xF8; next edge IF/ID=0. With r2=8 → `PCSrc`=0.
- `j 0x0000040` at PC+4=0x10000004 → `jump`=1, `pc_jump`=0x10000100, following slot flushed.
- (macro on) `lw r3,0(r0)` followed by `add r4,r3,r3` → `stall`=1 for 1 cycle, ID/EX control bubble=0, IF/ID held, then add issues. Macro off → `stall`=0.
- Write to r0 with 0xFFFF, then read r0 → 0; `andi` imm 0x8000 → `ex_sign_ext`=0x00008000.
